// File: rtl/alu16_reg_if.sv
// Operand/result bundle for the registered 16-bit execute-stage ALU.
// The master drives opcode and operands; the slave returns registered result and flags.
interface alu16_reg_if;
    logic [2:0]  alu_op;
    logic [15:0] src0;
    logic [15:0] src1;
    logic [15:0] result;
    logic [2:0]  flags;

    modport master (
        output alu_op, src0, src1,
        input  result, flags
    );

    modport slave (
        input  alu_op, src0, src1,
        output result, flags
    );
endinterface

// File: rtl/alu16_reg.sv
// Registered 16-bit ALU: saturating add/sub, paired-byte saturating add, AND/NOR, shifts.
// Macro ALU_PADDSB_EN enables the byte-lane adder; without it opcode 001 aliases ADD.
module alu16_reg (
    input  logic        clk,
    input  logic        rst,
    alu16_reg_if.slave  bus
);
    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_PADDSB = 3'b001;
    localparam logic [2:0] OP_SUB    = 3'b010;
    localparam logic [2:0] OP_AND    = 3'b011;
    localparam logic [2:0] OP_NOR    = 3'b100;
    localparam logic [2:0] OP_SLL    = 3'b101;
    localparam logic [2:0] OP_SRL    = 3'b110;
    localparam logic [2:0] OP_SRA    = 3'b111;

`ifdef ALU_PADDSB_EN
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] s;
        s = a + b;
        if ((a[7] == b[7]) && (s[7] != a[7]))
            return a[7] ? 8'h80 : 8'h7F;
        return s;
    endfunction
`endif

    logic [15:0] add_raw;
    logic [15:0] sub_raw;
    logic        add_ov;
    logic        sub_ov;
    logic [15:0] sat_val;
    logic [3:0]  shamt;
    logic [15:0] res_nxt;
    logic        neg_nxt;
    logic        ov_nxt;
    logic        zr_nxt;

    assign add_raw = bus.src0 + bus.src1;
    assign sub_raw = bus.src0 - bus.src1;
    assign add_ov  = (bus.src0[15] == bus.src1[15]) && (add_raw[15] != bus.src0[15]);
    assign sub_ov  = (bus.src0[15] != bus.src1[15]) && (sub_raw[15] != bus.src0[15]);
    // Overflow can only go in the direction of src0's sign for both add and sub.
    assign sat_val = bus.src0[15] ? 16'h8000 : 16'h7FFF;
    assign shamt   = bus.src1[3:0];

    always_comb begin
        res_nxt = '0;
        neg_nxt = 1'b0;
        ov_nxt  = 1'b0;
        zr_nxt  = 1'b0;
        case (bus.alu_op)
            OP_ADD: begin
                res_nxt = add_ov ? sat_val : add_raw;
                ov_nxt  = add_ov;
                neg_nxt = res_nxt[15];
                zr_nxt  = (res_nxt == 16'h0000);
            end
            OP_PADDSB: begin
`ifdef ALU_PADDSB_EN
                res_nxt = {sat_add8(bus.src0[15:8], bus.src1[15:8]),
                           sat_add8(bus.src0[7:0],  bus.src1[7:0])};
`else
                res_nxt = add_ov ? sat_val : add_raw;
                ov_nxt  = add_ov;
                neg_nxt = res_nxt[15];
                zr_nxt  = (res_nxt == 16'h0000);
`endif
            end
            OP_SUB: begin
                res_nxt = sub_ov ? sat_val : sub_raw;
                ov_nxt  = sub_ov;
                neg_nxt = res_nxt[15];
                zr_nxt  = (res_nxt == 16'h0000);
            end
            OP_AND: begin
                res_nxt = bus.src0 & bus.src1;
                zr_nxt  = (res_nxt == 16'h0000);
            end
            OP_NOR: begin
                res_nxt = ~(bus.src0 | bus.src1);
                zr_nxt  = (res_nxt == 16'h0000);
            end
            OP_SLL: begin
                res_nxt = bus.src0 << shamt;
                zr_nxt  = (res_nxt == 16'h0000);
            end
            OP_SRL: begin
                res_nxt = bus.src0 >> shamt;
                zr_nxt  = (res_nxt == 16'h0000);
            end
            OP_SRA: begin
                res_nxt = $unsigned($signed(bus.src0) >>> shamt);
                zr_nxt  = (res_nxt == 16'h0000);
            end
            default: begin
                res_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.result <= 16'h0000;
            bus.flags  <= 3'b000;
        end else begin
            bus.result <= res_nxt;
            bus.flags  <= {neg_nxt, ov_nxt, zr_nxt};
        end
    end
endmodule

// File: tb/tb_alu16_reg.sv
// Directed bench for alu16_reg: hand-computed vectors per opcode plus async reset behaviour.
module tb_alu16_reg;
    logic clk;
    logic rst;
    int   checks;
    int   fails;

    alu16_reg_if bus ();

    alu16_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out(input string tag, input logic [15:0] exp_res, input logic [2:0] exp_flags);
        checks++;
        assert (bus.result === exp_res) else begin
            fails++;
            $error("FAIL %s result observed=%h expected=%h", tag, bus.result, exp_res);
        end
        checks++;
        assert (bus.flags === exp_flags) else begin
            fails++;
            $error("FAIL %s flags observed=%b expected=%b", tag, bus.flags, exp_flags);
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp_res, input logic [2:0] exp_flags);
        @(negedge clk);
        bus.alu_op = op;
        bus.src0   = a;
        bus.src1   = b;
        @(posedge clk);
        #1;
        check_out(tag, exp_res, exp_flags);
    endtask

    initial begin
        checks     = 0;
        fails      = 0;
        rst        = 1'b1;
        bus.alu_op = 3'b000;
        bus.src0   = 16'h1234;
        bus.src1   = 16'h1111;
        #1;
        check_out("reset_t0", 16'h0000, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_hold", 16'h0000, 3'b000);
        @(negedge clk);
        rst = 1'b0;

        do_op("add_pos_sat", 3'b000, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b010);
        do_op("add_neg_sat", 3'b000, 16'h8000, 16'hFFFF, 16'h8000, 3'b110);
        do_op("add_plain",   3'b000, 16'h1234, 16'h1111, 16'h2345, 3'b000);
        do_op("add_zero",    3'b000, 16'hFFFF, 16'h0001, 16'h0000, 3'b001);
        do_op("sub_zero",    3'b010, 16'h0005, 16'h0005, 16'h0000, 3'b001);
        do_op("sub_neg",     3'b010, 16'h0003, 16'h0005, 16'hFFFE, 3'b100);
        do_op("sub_pos_sat", 3'b010, 16'h7FFF, 16'hFFFF, 16'h7FFF, 3'b010);
        do_op("sub_neg_sat", 3'b010, 16'h8000, 16'h0001, 16'h8000, 3'b110);
`ifdef ALU_PADDSB_EN
        do_op("paddsb_sat",   3'b001, 16'h7F80, 16'h0180, 16'h7F80, 3'b000);
        do_op("paddsb_plain", 3'b001, 16'h1020, 16'h0305, 16'h1325, 3'b000);
        do_op("paddsb_nocarry", 3'b001, 16'h00FF, 16'h0001, 16'h0000, 3'b000);
`else
        do_op("paddsb_as_add_sat", 3'b001, 16'h7F80, 16'h0180, 16'h7FFF, 3'b010);
        do_op("paddsb_as_add",     3'b001, 16'h1020, 16'h0305, 16'h1325, 3'b000);
        do_op("paddsb_as_add_carry", 3'b001, 16'h00FF, 16'h0001, 16'h0100, 3'b000);
`endif
        do_op("and_plain",  3'b011, 16'hF0F0, 16'h3C3C, 16'h3030, 3'b000);
        do_op("and_zero",   3'b011, 16'hF0F0, 16'h0F0F, 16'h0000, 3'b001);
        do_op("nor_zero",   3'b100, 16'hFFFF, 16'h0000, 16'h0000, 3'b001);
        do_op("nor_ones",   3'b100, 16'h0000, 16'h0000, 16'hFFFF, 3'b000);
        do_op("sll_15",     3'b101, 16'h0001, 16'h000F, 16'h8000, 3'b000);
        do_op("sll_0",      3'b101, 16'h0001, 16'h0010, 16'h0001, 3'b000);
        do_op("srl_15",     3'b110, 16'h8000, 16'h000F, 16'h0001, 3'b000);
        do_op("srl_0",      3'b110, 16'h8000, 16'hFFF0, 16'h8000, 3'b000);
        do_op("sra_4",      3'b111, 16'h8000, 16'h0004, 16'hF800, 3'b000);
        do_op("sra_0",      3'b111, 16'h1234, 16'h0000, 16'h1234, 3'b000);
        do_op("sra_zero",   3'b111, 16'h7000, 16'h000F, 16'h0000, 3'b001);

        // Mid-cycle reset clears outputs without an edge; the op sampled during reset is lost.
        do_op("pre_reset_op", 3'b000, 16'h0100, 16'h0023, 16'h0123, 3'b000);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_reset", 16'h0000, 3'b000);
        @(negedge clk);
        bus.alu_op = 3'b100;
        bus.src0   = 16'h0000;
        bus.src1   = 16'h00FF;
        @(posedge clk);
        #1;
        check_out("in_flight_lost", 16'h0000, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_out("first_after_reset", 16'hFF00, 3'b000);
        do_op("post_reset_sub", 3'b010, 16'h0010, 16'h0011, 16'hFFFF, 3'b100);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
